// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      I_BUSY = 2'd1,
      D_BUSY = 2'd2
   } arb_state_e;

   localparam int SEL_W = 4;
   localparam logic [SEL_W-1:0] SEL_ALL = 4'hF;

endpackage

// File: rtl/mem_arb_watchdog.sv
// BUSY-state watchdog: cleared on grant, counts BUSY cycles, flags the final allowed cycle.
module mem_arb_watchdog
   import mem_arb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic count,
   output logic expire
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // cnt_q holds the number of BUSY cycles already elapsed before this one
   assign expire = count && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (load)
         cnt_d = '0;
      else if (count && !expire)
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between a fetch and a data requester.
// Define MEM_ARB_TIMEOUT_EN to build in the BUSY watchdog and err abort pulse.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_valid,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [SEL_W-1:0]  d_sel,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_valid,
   output logic              mem_ce,
   output logic              mem_we,
   output logic [SEL_W-1:0]  mem_sel,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              stall_if,
   output logic              stall_mem,
   output logic              err
);

   arb_state_e        state_q, state_d;
   logic              if_starved_q, if_starved_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              we_q, we_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic              if_valid_q, if_valid_d;
   logic              d_valid_q, d_valid_d;

   logic if_live, d_live, grant_d, grant_i, busy, finish, expire;

   // a requester whose completion is showing this cycle is not re-granted
   assign if_live = if_req & ~if_valid_q;
   assign d_live  = d_req & ~d_valid_q;
   assign grant_d = (state_q == IDLE) & d_live & ~(if_live & if_starved_q);
   assign grant_i = (state_q == IDLE) & if_live & ~grant_d;
   assign busy    = (state_q != IDLE);
   assign finish  = busy & (mem_ack | expire);

`ifdef MEM_ARB_TIMEOUT_EN
   logic err_q, err_d;

   mem_arb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
      .clk    (clk),
      .rst    (rst),
      .load   (grant_d | grant_i),
      .count  (busy),
      .expire (expire)
   );

   // ack on the expiry cycle wins, so err only marks a true abort
   assign err_d = busy & expire & ~mem_ack;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) err_q <= 1'b0;
      else     err_q <= err_d;
   end

   assign err = err_q;
`else
   assign expire = 1'b0;
   assign err    = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (grant_d)      state_d = D_BUSY;
            else if (grant_i) state_d = I_BUSY;
         end
         I_BUSY, D_BUSY: begin
            if (mem_ack || expire) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mem_ce  = 1'b0;
      mem_we  = 1'b0;
      mem_sel = '0;
      unique case (state_q)
         I_BUSY: begin
            mem_ce  = 1'b1;
            mem_sel = SEL_ALL;
         end
         D_BUSY: begin
            mem_ce  = 1'b1;
            mem_we  = we_q;
            mem_sel = sel_q;
         end
         default: ;
      endcase
   end

   always_comb begin
      if_starved_d = if_starved_q;
      addr_d       = addr_q;
      we_d         = we_q;
      sel_d        = sel_q;
      wdata_d      = wdata_q;
      if_rdata_d   = if_rdata_q;
      d_rdata_d    = d_rdata_q;
      if_valid_d   = 1'b0;
      d_valid_d    = 1'b0;
      if (grant_d) begin
         addr_d  = d_addr;
         we_d    = d_we;
         sel_d   = d_sel;
         wdata_d = d_wdata;
         if (if_live) if_starved_d = 1'b1;
      end else if (grant_i) begin
         addr_d       = if_addr;
         if_starved_d = 1'b0;
      end
      if (finish && state_q == I_BUSY) begin
         if_valid_d = 1'b1;
         if_rdata_d = mem_ack ? mem_rdata : '0;
      end
      if (finish && state_q == D_BUSY) begin
         d_valid_d = 1'b1;
         d_rdata_d = mem_ack ? mem_rdata : '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         if_starved_q <= 1'b0;
         addr_q       <= '0;
         we_q         <= 1'b0;
         sel_q        <= '0;
         wdata_q      <= '0;
         if_rdata_q   <= '0;
         d_rdata_q    <= '0;
         if_valid_q   <= 1'b0;
         d_valid_q    <= 1'b0;
      end else begin
         if_starved_q <= if_starved_d;
         addr_q       <= addr_d;
         we_q         <= we_d;
         sel_q        <= sel_d;
         wdata_q      <= wdata_d;
         if_rdata_q   <= if_rdata_d;
         d_rdata_q    <= d_rdata_d;
         if_valid_q   <= if_valid_d;
         d_valid_q    <= d_valid_d;
      end
   end

   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign if_rdata  = if_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign if_valid  = if_valid_q;
   assign d_valid   = d_valid_q;
   assign stall_if  = if_req & ~if_valid_q;
   assign stall_mem = d_req & ~d_valid_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a transaction-level reference model checked every cycle.
module tb_mem_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 8;
`ifdef MEM_ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          if_req, if_valid, d_req, d_we, d_valid;
   logic [AW-1:0] if_addr, d_addr, mem_addr;
   logic [DW-1:0] if_rdata, d_rdata, d_wdata, mem_wdata, mem_rdata;
   logic [3:0]    d_sel, mem_sel;
   logic          mem_ce, mem_we, mem_ack, stall_if, stall_mem, err;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
      .d_req(d_req), .d_we(d_we), .d_sel(d_sel), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_valid(d_valid),
      .mem_ce(mem_ce), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .stall_if(stall_if), .stall_mem(stall_mem), .err(err)
   );

   int chk_cnt  = 0;
   int pass_cnt = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // memory responder: acks on the ack_delay-th BUSY cycle, data = rd_base ^ address
   bit            resp_en   = 1'b1;
   bit            force_ack = 1'b0;
   int            ack_delay = 1;
   logic [DW-1:0] rd_base   = 32'h1234_0000;
   int            bc        = 0;

   initial begin
      mem_ack   = 1'b0;
      mem_rdata = '0;
      forever begin
         @(posedge clk);
         #2;
         if (force_ack) begin
            mem_ack   = 1'b1;
            mem_rdata = rd_base;
         end else if (mem_ce && resp_en) begin
            bc++;
            if (bc == ack_delay) begin
               mem_ack   = 1'b1;
               mem_rdata = rd_base ^ mem_addr;
               bc        = 0;
            end else begin
               mem_ack = 1'b0;
            end
         end else begin
            mem_ack = 1'b0;
            bc      = 0;
         end
      end
   end

   // reference model: who owns the memory, what each requester should see next cycle
   bit            m_on = 1'b0;
   bit            m_busy, m_own_d, m_starved, m_ifv, m_dv, m_err, m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata, m_rd_if, m_rd_d;
   logic [3:0]    m_sel;
   int            m_cnt;

   always @(negedge clk) begin
      bit            wi, wd, nifv, ndv, nerr;
      logic [DW-1:0] rdv;
      if (rst) begin
         m_on = 1'b1; m_busy = 0; m_own_d = 0; m_starved = 0; m_ifv = 0; m_dv = 0;
         m_err = 0; m_rd_if = '0; m_rd_d = '0; m_cnt = 0;
         chk("rst_mem_addr", mem_addr, 0);
      end
      if (m_on) begin
         chk("if_valid", if_valid, m_ifv);
         chk("d_valid", d_valid, m_dv);
         chk("if_rdata", if_rdata, m_rd_if);
         chk("d_rdata", d_rdata, m_rd_d);
         chk("err", err, m_err);
         chk("mem_ce", mem_ce, m_busy);
         chk("stall_if", stall_if, if_req & ~m_ifv);
         chk("stall_mem", stall_mem, d_req & ~m_dv);
         chk("mem_we", mem_we, (m_busy && m_own_d) ? m_we : 1'b0);
         chk("mem_sel", mem_sel, m_busy ? (m_own_d ? m_sel : 4'hF) : 4'h0);
         if (m_busy) chk("mem_addr", mem_addr, m_addr);
         if (m_busy && m_own_d) chk("mem_wdata", mem_wdata, m_wdata);
      end
      if (m_on && !rst) begin
         nifv = 0; ndv = 0; nerr = 0;
         if (m_busy) begin
            m_cnt++;
            if (mem_ack || (TO_EN && m_cnt == TO)) begin
               rdv  = mem_ack ? mem_rdata : '0;
               nerr = !mem_ack;
               if (m_own_d) begin m_rd_d = rdv; ndv = 1; end
               else begin m_rd_if = rdv; nifv = 1; end
               m_busy = 0;
            end
         end else begin
            wi = if_req && !m_ifv;
            wd = d_req && !m_dv;
            if (wd && !(wi && m_starved)) begin
               m_busy = 1; m_own_d = 1; m_cnt = 0;
               m_addr = d_addr; m_we = d_we; m_sel = d_sel; m_wdata = d_wdata;
               if (wi) m_starved = 1;
            end else if (wi) begin
               m_busy = 1; m_own_d = 0; m_cnt = 0; m_addr = if_addr; m_starved = 0;
            end
         end
         m_ifv = nifv; m_dv = ndv; m_err = nerr;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      int            n, busy_n, ok_n, g, seen;
      bit            prev_ce;
      logic [AW-1:0] grants [4];
      rst = 1'b1; if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_sel = '0;
      d_addr = '0; d_wdata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("r_if_valid", if_valid, 0);   chk("r_d_valid", d_valid, 0);
      chk("r_mem_ce", mem_ce, 0);       chk("r_mem_we", mem_we, 0);
      chk("r_mem_sel", mem_sel, 0);     chk("r_err", err, 0);
      chk("r_if_rdata", if_rdata, 0);   chk("r_d_rdata", d_rdata, 0);
      chk("r_mem_addr", mem_addr, 0);
      tick(); rst = 1'b0;

      // fetch only, ack on second BUSY cycle
      tick();
      ack_delay = 2; rd_base = 32'h3C010001 ^ 32'h100;
      if_addr = 32'h100; if_req = 1;
      @(negedge clk);
      chk("t1_stall_if_wait", stall_if, 1);
      n = 0; ok_n = 1;
      while (!if_valid && n < 20) begin
         @(negedge clk); n++;
         if (!if_valid && !stall_if) ok_n = 0;
      end
      chk("t1_latency", n, 3);
      chk("t1_stall_held", ok_n, 1);
      chk("t1_if_rdata", if_rdata, 32'h3C010001);
      chk("t1_stall_at_valid", stall_if, 0);
      tick(); if_req = 0;
      @(negedge clk);
      chk("t1_single_pulse", if_valid, 0);
      chk("t1_rdata_hold", if_rdata, 32'h3C010001);

      // continuous contention
      tick();
      ack_delay = 1; rd_base = 32'h5000_0000;
      if_addr = 32'h300; d_addr = 32'h200; d_we = 0; d_sel = 4'hF;
      if_req = 1; d_req = 1;
      g = 0; n = 0; prev_ce = 0;
      while (g < 4 && n < 40) begin
         @(negedge clk); n++;
         if (mem_ce && !prev_ce) begin grants[g] = mem_addr; g++; end
         prev_ce = mem_ce;
      end
      chk("t2_grant_count", g, 4);
      chk("t2_grant0_D", grants[0], 32'h200);
      chk("t2_grant1_I", grants[1], 32'h300);
      chk("t2_grant2_D", grants[2], 32'h200);
      chk("t2_grant3_I", grants[3], 32'h300);
      tick(); d_req = 0;
      n = 0;
      do begin @(negedge clk); n++; end while (!if_valid && n < 20);
      chk("t2_last_if_valid", if_valid, 1);
      chk("t2_last_if_rdata", if_rdata, 32'h5000_0300);
      chk("t2_d_rdata", d_rdata, 32'h5000_0200);
      tick(); if_req = 0;

      // data write, three BUSY cycles
      tick();
      ack_delay = 3;
      d_we = 1; d_sel = 4'b0011; d_wdata = 32'hDEADBEEF; d_addr = 32'h240; d_req = 1;
      n = 0; busy_n = 0; ok_n = 0;
      do begin
         @(negedge clk); n++;
         if (mem_ce) begin
            busy_n++;
            if (mem_we && mem_sel == 4'b0011 && mem_wdata == 32'hDEADBEEF) ok_n++;
         end
      end while (!d_valid && n < 20);
      chk("t3_d_valid", d_valid, 1);
      chk("t3_busy_cycles", busy_n, 3);
      chk("t3_write_drive", ok_n, 3);
      chk("t3_d_rdata", d_rdata, 32'h5000_0240);
      tick(); d_req = 0; d_we = 0;

      // reset in the middle of D_BUSY, late ack afterwards
      resp_en = 0;
      tick();
      d_addr = 32'h280; d_sel = 4'hF; d_req = 1;
      tick();
      @(negedge clk);
      chk("t4_busy", mem_ce, 1);
      @(posedge clk); #3;
      rst = 1; d_req = 0;
      #1;
      chk("t4_rst_mem_ce", mem_ce, 0);   chk("t4_rst_mem_addr", mem_addr, 0);
      chk("t4_rst_d_valid", d_valid, 0); chk("t4_rst_mem_sel", mem_sel, 0);
      chk("t4_rst_d_rdata", d_rdata, 0);
      tick(); rst = 0; force_ack = 1;
      tick(); force_ack = 0;
      seen = 0;
      repeat (3) begin @(negedge clk); if (d_valid || if_valid || mem_ce) seen++; end
      chk("t4_no_activity", seen, 0);
      resp_en = 1;

      // ack while idle
      tick(); force_ack = 1;
      tick(); force_ack = 0;
      seen = 0;
      repeat (3) begin @(negedge clk); if (d_valid || if_valid || mem_ce) seen++; end
      chk("t5_idle_ack_ignored", seen, 0);
      chk("t5_d_rdata_hold", d_rdata, 0);

`ifdef MEM_ARB_TIMEOUT_EN
      // no ack: abort after TO BUSY cycles
      resp_en = 0;
      tick(); d_addr = 32'h400; d_req = 1;
      n = 0; busy_n = 0;
      do begin @(negedge clk); n++; if (mem_ce) busy_n++; end while (!d_valid && n < 40);
      chk("t6_abort_valid", d_valid, 1);
      chk("t6_abort_busy", busy_n, TO);
      chk("t6_abort_err", err, 1);
      chk("t6_abort_rdata", d_rdata, 0);
      tick(); d_req = 0;
      // ack lands on the expiry cycle
      resp_en = 1; ack_delay = TO;
      tick(); d_addr = 32'h404; d_req = 1;
      n = 0; busy_n = 0;
      do begin @(negedge clk); n++; if (mem_ce) busy_n++; end while (!d_valid && n < 40);
      chk("t6_ack_valid", d_valid, 1);
      chk("t6_ack_busy", busy_n, TO);
      chk("t6_ack_err", err, 0);
      chk("t6_ack_rdata", d_rdata, 32'h5000_0404);
      tick(); d_req = 0;
`endif

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32: byte-address width of all address ports.
REQ-002 Parameter DATA_W, default 32: data width of all data ports.
REQ-003 Parameter TIMEOUT_CYCLES, default 255: watchdog limit in cycles, used only when the watchdog is compiled in.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous and active-high.
REQ-006 Fetch requester ports SHALL be: if_req in 1 (level request), if_addr in ADDR_W, if_rdata out DATA_W, if_valid out 1 (completion pulse).
REQ-007 Data requester ports SHALL be: d_req in 1, d_we in 1, d_sel in 4 (byte enables), d_addr in ADDR_W, d_wdata in DATA_W, d_rdata out DATA_W, d_valid out 1.
REQ-008 Memory-side ports SHALL be: mem_ce out 1, mem_we out 1, mem_sel out 4, mem_addr out ADDR_W, mem_wdata out DATA_W, mem_rdata in DATA_W, mem_ack in 1.
REQ-009 Pipeline control ports SHALL be: stall_if out 1, stall_mem out 1, err out 1 (watchdog abort pulse).

Function
REQ-010 The block SHALL share one single-ported memory between the fetch and data requesters, using FSM states IDLE, I_BUSY and D_BUSY.
REQ-011 Requesters SHALL hold req and operands stable until their valid pulse; the arbiter samples them only in IDLE.
REQ-012 In IDLE with only d_req, the block SHALL latch the data operands and go to D_BUSY; with only if_req, it SHALL latch if_addr and go to I_BUSY.
REQ-013 In IDLE with both requests, data SHALL win unless flag if_starved is set, in which case fetch SHALL win.
REQ-014 if_starved SHALL set when fetch loses a contested grant and SHALL clear on any fetch grant, giving strict alternation under continuous contention.
REQ-015 In a BUSY state the block SHALL drive mem_ce=1 and mem_addr/mem_we/mem_sel/mem_wdata from the latched registers, and SHALL force mem_we=0 and mem_sel=4'hF in I_BUSY.
REQ-016 In IDLE the block SHALL drive mem_ce=0, mem_we=0 and mem_sel=0.
REQ-017 On mem_ack=1 in a BUSY state, the block SHALL register mem_rdata into the owner's rdata, pulse the owner's valid for exactly one cycle on the next cycle, and return to IDLE.
REQ-018 Minimum latency SHALL be: request sampled at edge N, mem_ce high from N+1, ack at earliest cycle N+1, valid in cycle N+2.
REQ-019 In the cycle a requester's valid is high, that requester's req SHALL be ignored, so no duplicate grant occurs; the other requester can be granted in that same cycle.
REQ-020 mem_ack received in IDLE SHALL be ignored.
REQ-021 rdata registers SHALL hold their value until the next completion for the same requester.
REQ-022 stall_if SHALL equal if_req & ~if_valid, and stall_mem SHALL equal d_req & ~d_valid, both combinational.
REQ-023 Write completions SHALL pulse d_valid, with d_rdata taking mem_rdata as received.

Reset
REQ-024 On rst=1, independent of clk, the block SHALL enter IDLE, clear if_starved, clear the watchdog counter, and drive if_valid=0, d_valid=0, mem_ce=0, mem_we=0, mem_sel=0, err=0, if_rdata=0, d_rdata=0 and mem_addr=0.
REQ-025 A reset during a BUSY state SHALL drop the transaction with no valid pulse, and a late mem_ack after reset SHALL be ignored.

Configuration
REQ-026 With macro MEM_ARB_TIMEOUT_EN defined, a counter SHALL count cycles in BUSY, and on reaching TIMEOUT_CYCLES without ack the block SHALL abort: owner valid=1, owner rdata=0 and err=1 for one cycle, then IDLE.
REQ-027 Without MEM_ARB_TIMEOUT_EN, the block SHALL contain no counter, err SHALL be tied to 0, and BUSY SHALL wait indefinitely for mem_ack.
REQ-028 mem_ack arriving in the same cycle as the timeout SHALL count as normal completion with err=0.

Structure
REQ-029 Package mem_arb_pkg SHALL hold the state encoding (IDLE/I_BUSY/D_BUSY), the byte-select width constant 4 and the all-bytes constant 4'hF.
REQ-030 The watchdog SHALL be a sub-module mem_arb_watchdog (load/count/expire), instantiated only under MEM_ARB_TIMEOUT_EN.

Verification
REQ-031 Fetch only: if_req=1 with if_addr=0x100, ack after 2 cycles with rdata=0x3C010001 -> if_valid is a single pulse, if_rdata=0x3C010001, stall_if is high until the pulse.
REQ-032 Simultaneous requests with if_starved=0: d_addr=0x200 is served first; while both are held, the grant order is D, I, D, I.
REQ-033 Data write: d_we=1, d_sel=4'b0011, d_wdata=0xDEADBEEF -> mem_we=1, mem_sel=0011 and mem_wdata=0xDEADBEEF for the whole BUSY state, then d_valid pulses.
REQ-034 Reset asserted mid D_BUSY, then mem_ack sent after reset -> no d_valid pulse, the FSM is in IDLE and all outputs are at their reset values.
REQ-035 With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, no ack -> after 8 BUSY cycles, valid=1, err=1, rdata=0; with the ack sent on cycle 8 -> err=0.
REQ-036 mem_ack pulsed while IDLE -> no valid pulse and no state change.
